// File: rtl/sys_reg_ctrl.sv
// sys_reg_ctrl: register-file initiator for the system controller path.
//   Decodes UART RX command frames (write: 0xAA,addr,data / read: 0xBB,addr),
//   drives the register-file write/read interface and pushes read results to
//   the TX FIFO.
// Optional build macro: FRAME_TIMEOUT_EN (inter-byte frame timeout of FRAME_TO
//   idle cycles; undefined -> controller waits indefinitely between bytes).
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   RX_P_DATA, RX_D_VLD  received byte and its one-cycle strobe
//   RdData, RD_D_Vld     register-file read data and its valid strobe
//   TX_FULL              TX FIFO full
//   WrEn, RdEn           one-cycle register-file write/read enables
//   Address, WrData      register-file address / write data (held between accesses)
//   TX_P_DATA, TX_D_VLD  byte to TX FIFO and its one-cycle write strobe
//   BUSY                 high whenever the controller is not idle
//   CMD_ERR              one-cycle error pulse
module sys_reg_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDRESS    = 4,
   parameter int RD_TIMEOUT = 4,
   parameter int FRAME_TO   = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RD_D_Vld,
   input  logic                  TX_FULL,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [ADDRESS-1:0]    Address,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   output logic                  BUSY,
   output logic                  CMD_ERR
);

   localparam logic [DATA_WIDTH-1:0] OP_WR = DATA_WIDTH'(8'hAA);
   localparam logic [DATA_WIDTH-1:0] OP_RD = DATA_WIDTH'(8'hBB);

   // One counter serves both the read-response timeout and the frame timeout.
   localparam int CNT_MAX = (RD_TIMEOUT > FRAME_TO) ? RD_TIMEOUT : FRAME_TO;
   localparam int CW      = $clog2(CNT_MAX + 1);
   localparam logic [CW-1:0] RD_LAST = CW'(RD_TIMEOUT - 1);
`ifdef FRAME_TIMEOUT_EN
   localparam logic [CW-1:0] FRM_LAST = CW'(FRAME_TO - 1);
`endif

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR,
      WR_DATA,
      RD_ADDR,
      RD_WAIT,
      TX_SEND
   } state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [ADDRESS-1:0]    addr_lat_q, addr_lat_d;
   logic [ADDRESS-1:0]    address_q, address_d;
   logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
   logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic                  tx_vld_q, tx_vld_d;
   logic                  busy_q, busy_d;
   logic                  err_q, err_d;
   logic [ADDRESS-1:0]    rx_addr;

   // Upper address-byte bits are ignored.
   assign rx_addr = RX_P_DATA[ADDRESS-1:0];

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_lat_d = addr_lat_q;
      address_d  = address_q;
      wr_data_d  = wr_data_q;
      tx_data_d  = tx_data_q;
      wr_en_d    = 1'b0;
      rd_en_d    = 1'b0;
      tx_vld_d   = 1'b0;
      err_d      = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (RX_D_VLD) begin
               if (RX_P_DATA == OP_WR)      state_d = WR_ADDR;
               else if (RX_P_DATA == OP_RD) state_d = RD_ADDR;
               else                         err_d   = 1'b1;
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_lat_d = rx_addr;
               cnt_d      = '0;
               state_d    = WR_DATA;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               address_d = addr_lat_q;
               wr_data_d = RX_P_DATA;
               state_d   = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               rd_en_d   = 1'b1;
               address_d = rx_addr;
               cnt_d     = '0;
               state_d   = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // A response on the last allowed cycle still wins over the timeout.
            // With TX room available the strobe goes out directly, skipping
            // TX_SEND, to keep RD_D_Vld -> TX_D_VLD at one cycle.
            if (RD_D_Vld) begin
               tx_data_d = RdData;
               if (TX_FULL) begin
                  state_d = TX_SEND;
               end else begin
                  tx_vld_d = 1'b1;
                  state_d  = IDLE;
               end
            end else if (cnt_q == RD_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            if (RX_D_VLD) err_d = 1'b1;
         end
         TX_SEND: begin
            if (!TX_FULL) begin
               tx_vld_d = 1'b1;
               state_d  = IDLE;
            end
            if (RX_D_VLD) err_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase

`ifdef FRAME_TIMEOUT_EN
      // Idle-cycle count between frame bytes; expiry abandons the frame.
      if ((state_q == WR_ADDR || state_q == WR_DATA || state_q == RD_ADDR) && !RX_D_VLD) begin
         if (cnt_q == FRM_LAST) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
`endif

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_lat_q <= '0;
         address_q  <= '0;
         wr_data_q  <= '0;
         tx_data_q  <= '0;
         wr_en_q    <= 1'b0;
         rd_en_q    <= 1'b0;
         tx_vld_q   <= 1'b0;
         busy_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_lat_q <= addr_lat_d;
         address_q  <= address_d;
         wr_data_q  <= wr_data_d;
         tx_data_q  <= tx_data_d;
         wr_en_q    <= wr_en_d;
         rd_en_q    <= rd_en_d;
         tx_vld_q   <= tx_vld_d;
         busy_q     <= busy_d;
         err_q      <= err_d;
      end
   end

   assign WrEn      = wr_en_q;
   assign RdEn      = rd_en_q;
   assign Address   = address_q;
   assign WrData    = wr_data_q;
   assign TX_P_DATA = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign BUSY      = busy_q;
   assign CMD_ERR   = err_q;

endmodule
